// File: rtl/ysyx_25040109_ifu_fetch_queue_pkg.sv
// Shared definitions for the IFU fetch queue and IDU-side decode.
// Entries are always packed as {pc, inst}, pc in the upper bits.
package ysyx_25040109_ifu_fetch_queue_pkg;

  localparam int FQ_DATA_W = 32;
  localparam int FQ_PC_W   = 32;
  localparam int FQ_ENTRY_W = FQ_PC_W + FQ_DATA_W;

  typedef struct packed {
    logic [FQ_PC_W-1:0]   pc;
    logic [FQ_DATA_W-1:0] inst;
  } fq_entry_t;

  function automatic fq_entry_t fq_pack(input logic [FQ_PC_W-1:0] pc,
                                        input logic [FQ_DATA_W-1:0] inst);
    fq_entry_t e;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

endpackage

// File: rtl/ysyx_25040109_ifu_fq_ram.sv
// Fetch queue storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the pointers.
module ysyx_25040109_ifu_fq_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_25040109_ifu_fetch_queue.sv
// DEPTH-entry circular fetch queue between instruction memory and the IDU.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module ysyx_25040109_ifu_fetch_queue
  import ysyx_25040109_ifu_fetch_queue_pkg::*;
#(
  parameter int DATA_W = FQ_DATA_W,
  parameter int PC_W   = FQ_PC_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic [PC_W-1:0]   imem_pc,
  input  logic              mem_valid,
  output logic              ifu_ready_to_mem,
  input  logic              flush,
  input  logic              idu_ready,
  output logic [DATA_W-1:0] inst_ifu,
  output logic [PC_W-1:0]   pc_ifu,
  output logic              ifu_valid_to_idu,
  output logic [CNT_W-1:0]  fq_count
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int ENTRY_W = PC_W + DATA_W;

  logic [CNT_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   rd_ptr;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                 (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]);

  // Ready never looks at mem_valid or idu_ready, so no combinational loop
  // can form with either neighbour; a full queue refuses even while popping.
  assign ifu_ready_to_mem = !full && !flush && !rst;
  assign ifu_valid_to_idu = !empty && !flush;

  assign push = mem_valid && ifu_ready_to_mem;
  assign pop  = ifu_valid_to_idu && idu_ready;

  assign fq_count = wr_ptr - rd_ptr;
  assign wr_entry = {imem_pc, imem_rdata};

  ysyx_25040109_ifu_fq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[IDX_W-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[IDX_W-1:0]),
    .rdata (head_entry)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage is never cleared, so the head is masked whenever it is not valid.
  assign pc_ifu   = ifu_valid_to_idu ? head_entry[ENTRY_W-1:DATA_W] : '0;
  assign inst_ifu = ifu_valid_to_idu ? head_entry[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_ysyx_25040109_ifu_fetch_queue.sv
// Randomised and directed bench for the IFU fetch queue, checked against a
// queue-based reference model of the specified behaviour.
module tb_ysyx_25040109_ifu_fetch_queue;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] imem_rdata = '0;
  logic [PC_W-1:0]   imem_pc = '0;
  logic              mem_valid = 1'b0;
  logic              ifu_ready_to_mem;
  logic              flush = 1'b0;
  logic              idu_ready = 1'b0;
  logic [DATA_W-1:0] inst_ifu;
  logic [PC_W-1:0]   pc_ifu;
  logic              ifu_valid_to_idu;
  logic [CNT_W-1:0]  fq_count;

  logic [63:0] modelQ[$];
  int passCount  = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  ysyx_25040109_ifu_fetch_queue #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_rdata       (imem_rdata),
    .imem_pc          (imem_pc),
    .mem_valid        (mem_valid),
    .ifu_ready_to_mem (ifu_ready_to_mem),
    .flush            (flush),
    .idu_ready        (idu_ready),
    .inst_ifu         (inst_ifu),
    .pc_ifu           (pc_ifu),
    .ifu_valid_to_idu (ifu_valid_to_idu),
    .fq_count         (fq_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
  endtask

  // One clock cycle: drive inputs at the falling edge, compare outputs against
  // the model, then update the model with what the rising edge must do.
  task automatic applyStimulus(input logic mv, input logic rdy, input logic fl,
                               input logic rs, input logic [31:0] pc,
                               input logic [31:0] ins, input bit doCheck,
                               output bit accepted);
    bit expFull, expReady, expValid, doPop, doPush;
    logic [63:0] expHead;
    @(negedge clk);
    mem_valid  = mv;
    idu_ready  = rdy;
    flush      = fl;
    rst        = rs;
    imem_pc    = pc;
    imem_rdata = ins;
    #1;
    expFull  = (modelQ.size() == DEPTH);
    expReady = !expFull && !fl && !rs;
    expValid = (modelQ.size() != 0) && !fl;
    expHead  = expValid ? modelQ[0] : 64'd0;
    if (doCheck) begin
      checkOutput("ready", 64'(ifu_ready_to_mem), 64'(expReady));
      checkOutput("valid", 64'(ifu_valid_to_idu), 64'(expValid));
      checkOutput("head_pc", 64'(pc_ifu), 64'(expHead[63:32]));
      checkOutput("head_inst", 64'(inst_ifu), 64'(expHead[31:0]));
      checkOutput("count", 64'(fq_count), 64'(modelQ.size()));
    end
    doPop    = expValid && rdy;
    doPush   = mv && expReady;
    accepted = doPush;
    @(posedge clk);
    if (rs || fl) begin
      modelQ.delete();
    end else begin
      if (doPop) void'(modelQ.pop_front());
      if (doPush) modelQ.push_back({pc, ins});
    end
  endtask

  initial begin
    bit acc;
    bit pending;
    logic [31:0] curPc;
    logic [31:0] curInst;

    // Reset; first cycle unchecked because pointers are still unknown.
    applyStimulus(0, 0, 0, 1, 0, 0, 0, acc);
    modelQ.delete();
    applyStimulus(0, 0, 0, 1, 0, 0, 1, acc);

    // Fill with the IDU stalled.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, 0, 0, 0, 32'h8000_0000 + 32'(4 * i), 32'h0000_0013 + 32'(i), 1, acc);
    #1;
    checkOutput("fill_count", 64'(fq_count), 64'd4);
    checkOutput("fill_ready", 64'(ifu_ready_to_mem), 64'd0);
    checkOutput("fill_head_pc", 64'(pc_ifu), 64'h8000_0000);
    checkOutput("fill_head_inst", 64'(inst_ifu), 64'h0000_0013);
    applyStimulus(1, 0, 0, 0, 32'h8000_0010, 32'h0000_0017, 1, acc);
    checkOutput("full_reject", 64'(acc), 64'd0);

    // Drain in order.
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(0, 1, 0, 0, 0, 0, 1, acc);
    #1;
    checkOutput("drained_valid", 64'(ifu_valid_to_idu), 64'd0);

    // Streaming with wrap-around.
    for (int i = 0; i < 20; i++)
      applyStimulus(1, 1, 0, 0, 32'h8000_0100 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1, acc);
    #1;
    checkOutput("stream_count", 64'(fq_count), 64'd1);
    checkOutput("stream_last_pc", 64'(pc_ifu), 64'h8000_014C);

    // Flush mid-stream with 3 entries queued and a beat on offer.
    applyStimulus(0, 1, 0, 0, 0, 0, 1, acc);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, 0, 0, 32'h8000_0200 + 32'(4 * i), 32'h2000_0000 + 32'(i), 1, acc);
    applyStimulus(1, 0, 1, 0, 32'h8000_0F00, 32'hDEAD_BEEF, 1, acc);
    #1;
    checkOutput("flush_count", 64'(fq_count), 64'd0);
    checkOutput("flush_valid", 64'(ifu_valid_to_idu), 64'd0);
    applyStimulus(1, 0, 0, 0, 32'h8000_1000, 32'h0000_0093, 1, acc);
    #1;
    checkOutput("post_flush_head", 64'(pc_ifu), 64'h8000_1000);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, acc);

    // Random backpressure; a beat is held until accepted.
    pending = 0;
    curPc   = 32'h9000_0000;
    curInst = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!pending) begin
        pending = bit'($urandom_range(0, 1));
        curInst = $urandom;
      end
      applyStimulus(pending, 1'($urandom_range(0, 1)), 0, 0, curPc, curInst, 1, acc);
      if (acc) begin
        pending = 0;
        curPc   = curPc + 32'd4;
      end
    end

    // Reset during operation with 2 entries queued.
    applyStimulus(0, 0, 1, 0, 0, 0, 1, acc);
    applyStimulus(1, 0, 0, 0, 32'h8000_2000, 32'h0000_0001, 1, acc);
    applyStimulus(1, 0, 0, 0, 32'h8000_2004, 32'h0000_0002, 1, acc);
    applyStimulus(0, 0, 0, 1, 0, 0, 1, acc);
    #1;
    checkOutput("rst_valid", 64'(ifu_valid_to_idu), 64'd0);
    checkOutput("rst_count", 64'(fq_count), 64'd0);
    checkOutput("rst_ready", 64'(ifu_ready_to_mem), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);
    #1;
    checkOutput("post_rst_ready", 64'(ifu_ready_to_mem), 64'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ysyx_25040109_ifu_fetch_queue.md
# ysyx_25040109_ifu_fetch_queue

Parametrised instruction-fetch queue between the instruction memory port and the IDU. It replaces the single-entry IFU valid/ready handshake stage with a DEPTH-entry circular buffer. Each fetched instruction is stored together with its PC. A synchronous flush discards all in-flight fetches on redirect.

## Interface
- DATA_W, 32: instruction width in bits.
- PC_W, 32: PC width in bits.
- DEPTH, 4: number of entries; power of two, ≥ 2.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width (derived; do not override).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_rdata  input  DATA_W  instruction from memory.
- imem_pc  input  PC_W  PC of imem_rdata.
- mem_valid  input  1  upstream valid.
- ifu_ready_to_mem  output  1  queue can accept this cycle.
- flush  input  1  redirect; empties the queue.
- idu_ready  input  1  downstream ready.
- inst_ifu  output  DATA_W  head instruction.
- pc_ifu  output  PC_W  head PC.
- ifu_valid_to_idu  output  1  head entry valid.
- fq_count  output  CNT_W  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {pc, inst}. Write pointer and read pointer are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- Empty when the pointers are equal. Full when the index bits are equal and the wrap bits differ. fq_count = wr_ptr − rd_ptr, modulo 2^CNT_W.
- push = mem_valid && ifu_ready_to_mem.
- pop = ifu_valid_to_idu && idu_ready.
- ifu_ready_to_mem = !full && !flush && !rst. This is combinational. There is no full-and-pop bypass: a full queue rejects a push even in a cycle where it pops.
- ifu_valid_to_idu = !empty && !flush.
- inst_ifu/pc_ifu show the head entry when ifu_valid_to_idu is high, and all zeros otherwise.
- Simultaneous push and pop when neither full nor empty: both pointers advance and the count is unchanged.
- Pop and push in the same cycle with count 1: the old head leaves, and the new entry becomes the head next cycle.
- Push into an empty queue: the entry is not visible in the same cycle (no combinational passthrough).
- Flush has priority over everything:
  - Both pointers reset to 0 on the next edge.
  - No push or pop happens in the flush cycle.
  - The upstream beat presented in that cycle is dropped, because ready is low.
- Reset: pointers at 0, so fq_count = 0 and ifu_valid_to_idu = 0. inst_ifu and pc_ifu read 0. ifu_ready_to_mem is 0 while rst is high and 1 in the first cycle after. Storage contents are not reset.
- Reset mid-stream: all entries are lost. This is the same as a flush.
- Upstream contract: a producer holds imem_rdata, imem_pc and mem_valid stable until the beat is accepted. The queue never drops a beat outside a flush cycle.

## Timing
- Latency from accept to visible at the head: 1 cycle. A push at edge N makes ifu_valid_to_idu high in cycle N+1.
- Throughput: 1 beat per cycle in steady state, as long as the queue is not full.
- Recovery from full: when the queue is full, a pop at edge N raises ifu_ready_to_mem in cycle N+1.
- ifu_ready_to_mem depends combinationally only on the state, rst and flush. It never depends on mem_valid or idu_ready, so no loops form with the neighbours.
- fq_count is registered-derived and updates on the edge after a push, pop or flush.

## Structure
- Shared package/header: the DATA_W and PC_W defaults and the entry-packing macro {pc, inst}, shared with IDU-side decode.
- Sub-module ysyx_25040109_ifu_fq_ram:
  - DEPTH×(PC_W+DATA_W) register array.
  - One write port and one asynchronous read port.
  - No reset on storage.
- Top level holds the pointers, the full/empty logic, the handshake and the flush logic.

## Test plan
- Reset then fill: DEPTH=4, hold idu_ready=0, present PCs 0x80000000..0x8000000C with insts 0x00000013+i.
  - Four beats are accepted and fq_count reaches 4.
  - In the fifth cycle ifu_ready_to_mem=0.
  - The head shows pc 0x80000000, inst 0x00000013.
- Drain in order: from the full queue, set idu_ready=1.
  - The IDU sees the four entries in order, one per cycle.
  - ifu_ready_to_mem rises the cycle after the first pop.
  - Valid drops after the fourth pop.
- Streaming with wrap-around: mem_valid=1 and idu_ready=1 continuously for 20 beats.
  - After the 1-cycle fill latency, one instruction is delivered per cycle.
  - fq_count stays at 1 and the pointers wrap correctly.
  - Output order matches input order.
- Flush mid-stream: 3 entries queued, assert flush for one cycle while mem_valid=1.
  - ready=0 and valid=0 in the flush cycle.
  - The next cycle has fq_count=0 and the beat presented during the flush cycle is not stored.
  - A new beat at 0x80001000 is the next head.
- Random backpressure: random mem_valid/idu_ready at 50% against a scoreboard, 10k cycles.
  - No loss, duplication or reorder.
  - Never ready while full, never valid while empty.
- Reset during operation: rst asserted with 2 entries queued.
  - The next cycle has valid=0, fq_count=0 and ready=0 while rst is high.
  - ready=1 in the first cycle after rst drops.
